// File: rtl/down_counter_sched.sv
// down_counter_sched: four requesters share one WIDTH-bit down counter.
// A granted channel gets its length loaded (ack pulse). The counter then
// decrements to zero, the channel receives a done pulse, and the block
// re-arbitrates.
// Arbitration is round-robin by default. Defining
// DOWN_COUNTER_SCHED_FIXED_PRIO_EN switches to fixed priority, where
// channel 0 is highest and channel 3 is lowest.
module down_counter_sched #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [3:0]           req,
    input  logic [4*WIDTH-1:0]   len,
    output logic [3:0]           ack,
    output logic [3:0]           done,
    output logic                 busy,
    output logic [1:0]           grant_id,
    output logic [WIDTH-1:0]     count
);

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [3:0]       ack_q, ack_d;
    logic [3:0]       done_q, done_d;
    logic             busy_q, busy_d;
    logic [1:0]       grant_q, grant_d;

    logic             winValid;
    logic [1:0]       winId;

`ifdef DOWN_COUNTER_SCHED_FIXED_PRIO_EN
    // Fixed priority: the lowest-numbered requesting channel wins.
    always_comb begin
        winValid = 1'b0;
        winId    = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (req[k]) begin
                winValid = 1'b1;
                winId    = 2'(k);
            end
        end
    end
`else
    logic [1:0] ptr_q, ptr_d;

    // Round-robin: search starts one past the last winner and wraps around.
    // Later loop iterations override earlier ones, so the loop walks from
    // the farthest candidate inward and the nearest candidate wins.
    always_comb begin
        logic [1:0] cand;
        winValid = 1'b0;
        winId    = 2'd0;
        cand     = 2'd0;
        for (int k = 4; k >= 1; k--) begin
            cand = ptr_q + 2'(k);
            if (req[cand]) begin
                winValid = 1'b1;
                winId    = cand;
            end
        end
    end

    // The pointer remembers the last winner. Its reset value is 3, so
    // channel 0 is searched first after reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q <= 2'd3;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    // Next-state logic. Requests and lengths are looked at only in IDLE;
    // in COUNT the counter runs down and then the owner's done is raised.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        ack_d   = 4'b0000;
        done_d  = 4'b0000;
        busy_d  = busy_q;
        grant_d = grant_q;
`ifndef DOWN_COUNTER_SCHED_FIXED_PRIO_EN
        ptr_d   = ptr_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (winValid) begin
                    count_d = len[winId*WIDTH +: WIDTH];
                    ack_d   = 4'b0001 << winId;
                    grant_d = winId;
                    busy_d  = 1'b1;
                    state_d = COUNT;
`ifndef DOWN_COUNTER_SCHED_FIXED_PRIO_EN
                    ptr_d   = winId;
`endif
                end
            end
            COUNT: begin
                if (count_q != '0) begin
                    count_d = count_q - WIDTH'(1);
                end else begin
                    done_d  = 4'b0001 << grant_q;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers. An asynchronous reset aborts any
    // countdown without issuing a done pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            count_q <= '1;
            ack_q   <= 4'b0000;
            done_q  <= 4'b0000;
            busy_q  <= 1'b0;
            grant_q <= 2'd0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            ack_q   <= ack_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            grant_q <= grant_d;
        end
    end

    assign ack      = ack_q;
    assign done     = done_q;
    assign busy     = busy_q;
    assign grant_id = grant_q;
    assign count    = count_q;

endmodule

// File: tb/tb_down_counter_sched.sv
// Testbench for down_counter_sched. The bench combines three kinds of
// stimulus: a table of vectors, hand-written corner sequences, and random
// traffic. Every output is compared with a transaction-level reference
// model each cycle. Honours DOWN_COUNTER_SCHED_FIXED_PRIO_EN.
module tb_down_counter_sched;

    localparam int W = 16;

    logic           clk;
    logic           reset;
    logic [3:0]     req;
    logic [4*W-1:0] len;
    logic [3:0]     ack;
    logic [3:0]     done;
    logic           busy;
    logic [1:0]     grant_id;
    logic [W-1:0]   count;

    int checkCount = 0;
    int passCount  = 0;

    // Reference model: a grant remembers its owner, its length and the
    // edge on which it was made. Count and done follow from elapsed edges.
    int         edgeCnt    = 0;
    bit         mActive    = 0;
    int         mPtr       = 3;
    int         mOwner     = 0;
    int         mGrantEdge = 0;
    int         mLen       = 0;
    logic [3:0] expAck     = 4'b0000;
    logic [3:0] expDone    = 4'b0000;
    logic       expBusy    = 1'b0;
    logic [1:0] expGrant   = 2'd0;
    logic [W-1:0] expCount = 16'hFFFF;

    typedef struct {
        logic [3:0]     req;
        logic [4*W-1:0] len;
        logic [3:0]     ack;
        logic [3:0]     done;
        logic           busy;
        logic [1:0]     grant;
        logic [W-1:0]   count;
    } vec_t;

    vec_t vecs[9];

    down_counter_sched #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .len      (len),
        .ack      (ack),
        .done     (done),
        .busy     (busy),
        .grant_id (grant_id),
        .count    (count)
    );

    // Free-running clock with a 10-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got %0h, expected %0h at t=%0t",
                      name, actual, expected, $time);
    endtask

    task automatic modelReset();
        mActive  = 0;
        mPtr     = 3;
        expAck   = 4'b0000;
        expDone  = 4'b0000;
        expBusy  = 1'b0;
        expGrant = 2'd0;
        expCount = 16'hFFFF;
    endtask

    task automatic modelEdge(input logic [3:0] reqS, input logic [4*W-1:0] lenS);
        int win;
        int elapsed;
        edgeCnt++;
        expAck  = 4'b0000;
        expDone = 4'b0000;
        if (mActive) begin
            elapsed = edgeCnt - mGrantEdge;
            if (elapsed > mLen) begin
                expDone  = 4'b0001 << mOwner;
                expBusy  = 1'b0;
                expCount = '0;
                mActive  = 0;
            end else begin
                expCount = W'(mLen - elapsed);
            end
        end else if (reqS != 4'b0000) begin
            win = -1;
`ifdef DOWN_COUNTER_SCHED_FIXED_PRIO_EN
            for (int k = 0; k < 4; k++)
                if (win < 0 && reqS[k]) win = k;
`else
            for (int k = 1; k <= 4; k++)
                if (win < 0 && reqS[(mPtr + k) % 4]) win = (mPtr + k) % 4;
`endif
            mPtr       = win;
            mOwner     = win;
            mActive    = 1;
            mGrantEdge = edgeCnt;
            mLen       = int'(lenS[win*W +: W]);
            expAck     = 4'b0001 << win;
            expBusy    = 1'b1;
            expGrant   = 2'(win);
            expCount   = lenS[win*W +: W];
        end
    endtask

    task automatic checkModel();
        checkOutput("ack",      32'(ack),      32'(expAck));
        checkOutput("done",     32'(done),     32'(expDone));
        checkOutput("busy",     32'(busy),     32'(expBusy));
        checkOutput("grant_id", 32'(grant_id), 32'(expGrant));
        checkOutput("count",    32'(count),    32'(expCount));
    endtask

    // Drive inputs, take one rising edge, advance the model, compare.
    task automatic applyStimulus(input logic [3:0] reqV, input logic [4*W-1:0] lenV);
        req = reqV;
        len = lenV;
        @(posedge clk);
        modelEdge(reqV, lenV);
        #1;
        checkModel();
    endtask

    // Pull reset mid-cycle, check the asynchronous effect, hold it across
    // one edge, and release it away from any edge.
    task automatic midCycleReset();
        #2;
        reset = 1'b0;
        #1;
        modelReset();
        checkOutput("rst_async_count", 32'(count), 32'hFFFF);
        checkOutput("rst_async_busy",  32'(busy),  32'd0);
        checkOutput("rst_async_done",  32'(done),  32'd0);
        checkOutput("rst_async_ack",   32'(ack),   32'd0);
        checkOutput("rst_async_grant", 32'(grant_id), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("rst_hold_done", 32'(done), 32'd0);
        checkModel();
        #2;
        reset = 1'b1;
    endtask

    initial begin
        logic [3:0]     curReq;
        logic [4*W-1:0] lenR;
        int             ackOrder[$];
        int             ackEdge[$];
        bit             sawAck3;
        int             otherAcks;

        // Single request on channel 2 (len 3), then zero length on channel 1.
        vecs[0] = '{4'b0100, {16'd0, 16'd3, 16'd0, 16'd0}, 4'b0100, 4'b0000, 1'b1, 2'd2, 16'd3};
        vecs[1] = '{4'b0000, {16'd0, 16'd3, 16'd0, 16'd0}, 4'b0000, 4'b0000, 1'b1, 2'd2, 16'd2};
        vecs[2] = '{4'b0000, {16'd0, 16'd3, 16'd0, 16'd0}, 4'b0000, 4'b0000, 1'b1, 2'd2, 16'd1};
        vecs[3] = '{4'b0000, {16'd0, 16'd3, 16'd0, 16'd0}, 4'b0000, 4'b0000, 1'b1, 2'd2, 16'd0};
        vecs[4] = '{4'b0000, {16'd0, 16'd3, 16'd0, 16'd0}, 4'b0000, 4'b0100, 1'b0, 2'd2, 16'd0};
        vecs[5] = '{4'b0000, {16'd0, 16'd3, 16'd0, 16'd0}, 4'b0000, 4'b0000, 1'b0, 2'd2, 16'd0};
        vecs[6] = '{4'b0010, {16'd9, 16'd9, 16'd0, 16'd9}, 4'b0010, 4'b0000, 1'b1, 2'd1, 16'd0};
        vecs[7] = '{4'b0000, {16'd9, 16'd9, 16'd0, 16'd9}, 4'b0000, 4'b0010, 1'b0, 2'd1, 16'd0};
        vecs[8] = '{4'b0000, {16'd9, 16'd9, 16'd0, 16'd9}, 4'b0000, 4'b0000, 1'b0, 2'd1, 16'd0};

        reset = 1'b0;
        req   = 4'b0000;
        len   = '0;
        modelReset();
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_count", 32'(count), 32'hFFFF);
        checkOutput("reset_ack",   32'(ack),   32'd0);
        checkOutput("reset_done",  32'(done),  32'd0);
        checkOutput("reset_busy",  32'(busy),  32'd0);
        checkOutput("reset_grant", 32'(grant_id), 32'd0);
        #2;
        reset = 1'b1;
        applyStimulus(4'b0000, '0);
        applyStimulus(4'b0000, '0);

        // Table-driven vectors.
        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i].req, vecs[i].len);
            checkOutput($sformatf("vec%0d_ack", i),   32'(ack),      32'(vecs[i].ack));
            checkOutput($sformatf("vec%0d_done", i),  32'(done),     32'(vecs[i].done));
            checkOutput($sformatf("vec%0d_busy", i),  32'(busy),     32'(vecs[i].busy));
            checkOutput($sformatf("vec%0d_grant", i), 32'(grant_id), 32'(vecs[i].grant));
            checkOutput($sformatf("vec%0d_count", i), 32'(count),    32'(vecs[i].count));
        end

        // Contention from a fresh reset: all four request, each with length 1.
        midCycleReset();
        curReq = 4'b1111;
        for (int c = 0; c < 16; c++) begin
            applyStimulus(curReq, {4{16'd1}});
            if (ack != 4'b0000) begin
                for (int b = 0; b < 4; b++) begin
                    if (ack[b]) begin
                        ackOrder.push_back(b);
                        ackEdge.push_back(c);
                    end
                end
`ifdef DOWN_COUNTER_SCHED_FIXED_PRIO_EN
                curReq = curReq & ~(ack & 4'b1110);
`else
                curReq = curReq & ~ack;
`endif
            end
        end
`ifdef DOWN_COUNTER_SCHED_FIXED_PRIO_EN
        otherAcks = 0;
        foreach (ackOrder[i]) if (ackOrder[i] != 0) otherAcks++;
        checkOutput("fixed_ack_total", 32'(ackOrder.size() >= 5), 32'd1);
        checkOutput("fixed_starved", 32'(otherAcks), 32'd0);
`else
        checkOutput("rr_ack_total", 32'(ackOrder.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < ackOrder.size()) begin
                checkOutput($sformatf("rr_order%0d", i), 32'(ackOrder[i]), 32'(i));
            end
            if (i > 0 && i < ackEdge.size()) begin
                checkOutput($sformatf("rr_gap%0d", i), 32'(ackEdge[i] - ackEdge[i-1]), 32'd3);
            end
        end
`endif
        for (int c = 0; c < 8; c++) applyStimulus(4'b0000, {4{16'd1}});
        checkOutput("contention_idle", 32'(busy), 32'd0);

        // Withdraw and ignore: channel 3 pulses during channel 0's count and
        // channel 0's length changes mid-count.
        applyStimulus(4'b0001, {16'd4, 16'd0, 16'd0, 16'd6});
        sawAck3 = 0;
        for (int c = 0; c < 9; c++) begin
            if (c == 1 || c == 2) curReq = 4'b1000;
            else curReq = 4'b0000;
            lenR = (c >= 2) ? {16'd4, 16'd0, 16'd0, 16'd100} : {16'd4, 16'd0, 16'd0, 16'd6};
            applyStimulus(curReq, lenR);
            if (ack[3]) sawAck3 = 1;
            if (c == 3) checkOutput("ignore_len_count", 32'(count), 32'd2);
        end
        checkOutput("withdraw_no_ack3", 32'(sawAck3), 32'd0);

        // Reset while channel 2 is at count 5, then a fresh full grant.
        applyStimulus(4'b0100, {16'd0, 16'd8, 16'd0, 16'd0});
        checkOutput("mid_ack2", 32'(ack), 32'b0100);
        for (int c = 0; c < 3; c++) applyStimulus(4'b0100, {16'd0, 16'd8, 16'd0, 16'd0});
        checkOutput("mid_count5", 32'(count), 32'd5);
        midCycleReset();
        applyStimulus(4'b0100, {16'd0, 16'd8, 16'd0, 16'd0});
        checkOutput("fresh_ack2", 32'(ack), 32'b0100);
        checkOutput("fresh_count", 32'(count), 32'd8);
        for (int c = 0; c < 10; c++) applyStimulus(4'b0000, {16'd0, 16'd8, 16'd0, 16'd0});

        // Random traffic against the model; requesters drop after their ack.
        curReq = 4'b0000;
        for (int n = 0; n < 600; n++) begin
            curReq = curReq & ~expAck;
            if ($urandom_range(0, 3) == 0) curReq = curReq | 4'($urandom_range(0, 15));
            if ($urandom_range(0, 9) == 0) curReq = curReq & 4'($urandom_range(0, 15));
            for (int ch = 0; ch < 4; ch++) lenR[ch*W +: W] = W'($urandom_range(0, 7));
            if ($urandom_range(0, 149) == 0) begin
                midCycleReset();
            end else begin
                applyStimulus(curReq, lenR);
            end
        end

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
